vga_fb_arbiter: RTL and testbench

- Shares one single-port 8-bit framebuffer RAM between two requesters: the display fetch path and a CPU-side read/write port.
- Each pixel is stored as three consecutive bytes (R, G, B).
- The block sequences the three byte reads per pixel and interleaves CPU accesses using fixed priority plus an anti-starvation rule.
- Sits between the VGA timing/line-buffer logic and the framebuffer altsyncram.

---
 rtl/vga_fb_arbiter.sv | 149 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one 8-bit framebuffer RAM between a 3-byte pixel fetch port (pix_*) and a CPU port (cpu_*) through a registered RAM port (mem_*); VGA_ARB_STATS_EN adds the cpu_stall_cnt output
module vga_fb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int PIX_W      = 14,
  parameter int FB_BASE    = 0,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              pix_req,
  input  logic [PIX_W-1:0]  pix_idx,
  output logic              pix_busy,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_r,
  output logic [DATA_W-1:0] pix_g,
  output logic [DATA_W-1:0] pix_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt
`endif
);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  typedef enum logic [3:0] {IDLE, PIX0, PIX1, PIX2, PIXD1, CPUW, CPUR1, CPUR2, ACK} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, base;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, pix_r_q, pix_r_d, pix_g_q, pix_g_d;
  logic [DATA_W-1:0] pix_b_q, pix_b_d, cpu_rdata_q, cpu_rdata_d;
  logic              mem_wren_q, mem_wren_d, pix_valid_q, pix_valid_d, cpu_ack_q, cpu_ack_d;
  logic              cpu_grant, pix_grant;
  assign base      = ADDR_W'(FB_BASE) + ADDR_W'(pix_idx) * ADDR_W'(3);
  assign cpu_grant = state_q == IDLE && cpu_req &&
                     (!pix_req || (STARVE_MAX != 0 && starve_q == SW'(STARVE_MAX)));
  assign pix_grant = state_q == IDLE && pix_req && !cpu_grant;
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    pix_r_d     = pix_r_q;
    pix_g_d     = pix_g_q;
    pix_b_d     = pix_b_q;
    pix_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    starve_d    = state_q != IDLE ? starve_q :
                  (!cpu_req || cpu_grant) ? '0 :
                  (pix_grant && starve_q != SW'(STARVE_MAX)) ? starve_q + SW'(1) : starve_q;
    case (state_q)
      IDLE: begin
        state_d     = cpu_grant ? (cpu_we ? CPUW : CPUR1) : pix_grant ? PIX0 : IDLE;
        mem_addr_d  = cpu_grant ? cpu_addr : pix_grant ? base : mem_addr_q;
        mem_wren_d  = cpu_grant && cpu_we;
        mem_wdata_d = cpu_grant && cpu_we ? cpu_wdata : mem_wdata_q;
      end
      PIX0: begin
        state_d    = PIX1;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
      PIX1: begin
        state_d    = PIX2;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        pix_r_d    = mem_q;
      end
      PIX2: begin
        state_d = PIXD1;
        pix_g_d = mem_q;
      end
      PIXD1: begin
        state_d     = IDLE;
        pix_b_d     = mem_q;
        pix_valid_d = 1'b1;
      end
      CPUW: begin
        state_d   = ACK;
        cpu_ack_d = 1'b1;
      end
      CPUR1: state_d = CPUR2;
      CPUR2: begin
        state_d     = ACK;
        cpu_rdata_d = mem_q;
        cpu_ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      pix_r_q     <= '0;
      pix_g_q     <= '0;
      pix_b_q     <= '0;
      pix_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      pix_r_q     <= pix_r_d;
      pix_g_q     <= pix_g_d;
      pix_b_q     <= pix_b_d;
      pix_valid_q <= pix_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end
  assign pix_busy  = state_q != IDLE;
  assign pix_valid = pix_valid_q;
  assign pix_r     = pix_r_q;
  assign pix_g     = pix_g_q;
  assign pix_b     = pix_b_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wren  = mem_wren_q;
  assign mem_wdata = mem_wdata_q;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic        serving;
  // the grant edge itself counts as serving, so the value seen at the grant equals the wait
  assign serving = cpu_grant || state_q inside {CPUW, CPUR1, CPUR2, ACK};
  always_comb begin
    stall_d = cpu_req && !serving && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign cpu_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed vector bench with RAM models for two arbiter instances (FB_BASE 0x30 / 0xFFFE)
module tb_vga_fb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic pix_req = 0, cpu_req = 0, cpu_we = 0;
  logic [13:0] pix_idx = '0;
  logic [15:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic pix_busy, pix_valid, cpu_ack, mem_wren;
  logic [7:0] pix_r, pix_g, pix_b, cpu_rdata, mem_wdata, mem_q;
  logic [15:0] mem_addr;
  logic pix_req1 = 0, cpu_req1 = 0, cpu_we1 = 0;
  logic [13:0] pix_idx1 = '0;
  logic [15:0] cpu_addr1 = '0;
  logic [7:0] cpu_wdata1 = '0;
  logic pix_busy1, pix_valid1, cpu_ack1, mem_wren1;
  logic [7:0] pix_r1, pix_g1, pix_b1, cpu_rdata1, mem_wdata1, mem_q1;
  logic [15:0] mem_addr1;
  logic bd_we = 0, bd_sel = 0;
  logic [15:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  logic [7:0] ram0 [0:65535];
  logic [7:0] ram1 [0:65535];
  logic [15:0] ra0, ra1;
  int checks = 0, errors = 0;

  vga_fb_arbiter #(.FB_BASE(16'h0030), .STARVE_MAX(2)) u0 (
    .CLOCK_50(clk), .reset(reset), .pix_req(pix_req), .pix_idx(pix_idx),
    .pix_busy(pix_busy), .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_wdata(mem_wdata), .mem_q(mem_q));

  vga_fb_arbiter #(.FB_BASE(16'hFFFE)) u1 (
    .CLOCK_50(clk), .reset(reset), .pix_req(pix_req1), .pix_idx(pix_idx1),
    .pix_busy(pix_busy1), .pix_valid(pix_valid1), .pix_r(pix_r1), .pix_g(pix_g1), .pix_b(pix_b1),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
    .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1), .mem_addr(mem_addr1), .mem_wren(mem_wren1),
    .mem_wdata(mem_wdata1), .mem_q(mem_q1));

  always @(posedge clk) begin
    if (bd_we && !bd_sel) ram0[bd_addr] <= bd_data;
    else if (mem_wren) ram0[mem_addr] <= mem_wdata;
    ra0 <= mem_addr;
  end
  assign mem_q = ram0[ra0];

  always @(posedge clk) begin
    if (bd_we && bd_sel) ram1[bd_addr] <= bd_data;
    else if (mem_wren1) ram1[mem_addr1] <= mem_wdata1;
    ra1 <= mem_addr1;
  end
  assign mem_q1 = ram1[ra1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cpu(input logic we, input logic [15:0] a, input logic [7:0] d, input logic [7:0] exp);
    int n;
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clk);
    @(negedge clk);
    cpu_we = ~we; cpu_addr = ~a; cpu_wdata = ~d;
    chk("cpu_mem_addr", mem_addr, a);
    chk("cpu_mem_wren", mem_wren, we);
    if (we) chk("cpu_mem_wdata", mem_wdata, d);
    n = 1;
    while (!cpu_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cpu_ack_latency", n, we ? 2 : 3);
    if (!we) chk("cpu_rdata", cpu_rdata, exp);
    chk("cpu_wren_low_at_ack", mem_wren, 0);
    cpu_req = 0;
    @(negedge clk);
    chk("cpu_ack_one_cycle", cpu_ack, 0);
  endtask

  task automatic do_pix(input logic [13:0] idx, input logic [15:0] base, input logic [23:0] exp);
    int n;
    logic [15:0] b;
    b = base;
    @(negedge clk);
    pix_req = 1; pix_idx = idx;
    @(posedge clk);
    @(negedge clk);
    pix_req = 0; pix_idx = ~idx;
    chk("pix_addr0", mem_addr, b);
    chk("pix_busy", pix_busy, 1);
    b = b + 16'd1;
    @(negedge clk);
    chk("pix_addr1", mem_addr, b);
    b = b + 16'd1;
    @(negedge clk);
    chk("pix_addr2", mem_addr, b);
    n = 3;
    while (!pix_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("pix_valid_latency", n, 5);
    chk("pix_rgb", {pix_r, pix_g, pix_b}, exp);
    chk("pix_busy_done", pix_busy, 0);
    @(negedge clk);
    chk("pix_valid_one_cycle", pix_valid, 0);
    chk("pix_rgb_held", {pix_r, pix_g, pix_b}, exp);
  endtask

  typedef struct {
    logic        pix;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [15:0] base;
    logic [23:0] exp;
  } vec_t;
  typedef struct {
    logic        sel;
    logic [15:0] a;
    logic [7:0]  d;
  } pl_t;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    pl_t pl[13];
    string seq;
    int n, nc, acks;
    logic re;
    pl = '{'{0, 16'h0030, 8'h11}, '{0, 16'h0031, 8'h22}, '{0, 16'h0032, 8'h33},
           '{0, 16'h0036, 8'h44}, '{0, 16'h0037, 8'h55}, '{0, 16'h0038, 8'h66},
           '{0, 16'h0200, 8'h77}, '{0, 16'h3AC8, 8'h0A}, '{0, 16'h3AC9, 8'h0B},
           '{0, 16'h3ACA, 8'h0C}, '{1, 16'hFFFE, 8'h01}, '{1, 16'hFFFF, 8'h02},
           '{1, 16'h0000, 8'h03}};
    vecs = '{'{0, 1, 16'h0100, 8'hA5, 16'h0000, 24'h0000A5},
             '{0, 0, 16'h0100, 8'h00, 16'h0000, 24'h0000A5},
             '{1, 0, 16'd0,     8'h00, 16'h0030, 24'h112233},
             '{1, 0, 16'd2,     8'h00, 16'h0036, 24'h445566},
             '{0, 1, 16'h0039, 8'hA1, 16'h0000, 24'h0},
             '{0, 1, 16'h003A, 8'hB2, 16'h0000, 24'h0},
             '{0, 1, 16'h003B, 8'hC3, 16'h0000, 24'h0},
             '{1, 0, 16'd3,     8'h00, 16'h0039, 24'hA1B2C3},
             '{0, 0, 16'h0037, 8'h00, 16'h0000, 24'h000055},
             '{0, 1, 16'hFFFF, 8'h5A, 16'h0000, 24'h0},
             '{0, 0, 16'hFFFF, 8'h00, 16'h0000, 24'h00005A},
             '{1, 0, 16'd5000,  8'h00, 16'h3AC8, 24'h0A0B0C},
             '{0, 0, 16'h0100, 8'h00, 16'h0000, 24'h0000A5}};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bd_we = 1; bd_sel = pl[i].sel; bd_addr = pl[i].a; bd_data = pl[i].d;
    end
    @(negedge clk);
    bd_we = 0;
    chk("rst_busy", pix_busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_rgb", {pix_r, pix_g, pix_b, cpu_rdata}, 0);
    reset = 0;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].pix) do_pix(vecs[i].addr[13:0], vecs[i].base, vecs[i].exp);
      else do_cpu(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp[7:0]);
    end
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'hEE;
    @(posedge clk);
    #1;
    chk("mid_cpuw_wren_high", mem_wren, 1);
    reset = 1;
    #1;
    chk("mid_cpuw_wren_async_low", mem_wren, 0);
    chk("mid_cpuw_addr_cleared", mem_addr, 0);
    cpu_req = 0;
    @(negedge clk);
    reset = 0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acks += int'(cpu_ack);
    end
    chk("post_rst_no_ack", acks, 0);
    chk("post_rst_busy", pix_busy, 0);
    chk("post_rst_outputs", {pix_r, pix_g, pix_b, cpu_rdata, mem_wdata}, 0);
    do_cpu(0, 16'h0200, 8'h00, 8'h77);
    @(negedge clk);
    pix_req = 1; pix_idx = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
    seq = ""; n = 0; nc = 0; re = 0;
    while (seq.len() < 6 && n < 150) begin
      @(negedge clk);
      n++;
      if (re) begin
        cpu_req = 1;
        re = 0;
      end
      if (pix_valid) seq = {seq, "P"};
      if (cpu_ack) begin
        seq = {seq, "C"};
        nc++;
        chk("arb_cpu_rdata", cpu_rdata, 8'h11);
        cpu_req = 0;
        re = nc == 1;
      end
    end
    pix_req = 0;
    checks++;
    if (seq != "PPCPPC") begin
      errors++;
      $display("FAIL arb_order actual %s expected PPCPPC", seq);
    end
    n = 0;
    while (pix_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("arb_drain", pix_busy, 0);
    @(negedge clk);
    pix_req1 = 1; pix_idx1 = 0;
    @(posedge clk);
    @(negedge clk);
    pix_req1 = 0; pix_idx1 = 14'h1FFF;
    chk("wrap_addr0", mem_addr1, 16'hFFFE);
    @(negedge clk);
    chk("wrap_addr1", mem_addr1, 16'hFFFF);
    @(negedge clk);
    chk("wrap_addr2", mem_addr1, 16'h0000);
    n = 3;
    while (!pix_valid1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_latency", n, 5);
    chk("wrap_rgb", {pix_r1, pix_g1, pix_b1}, 24'h010203);
    chk("u1_no_cpu_ack", cpu_ack1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
